// File: rtl/skew_mes_pkg.sv
// Shared types and default constants for the skew measurement controller.
// Contents: controller state enum and the default values of the DELAY_W,
// AVG_LOG2 and SETTLE_CYC parameters.
package skew_mes_pkg;
  localparam int DELAY_W_DEF    = 10;
  localparam int AVG_LOG2_DEF   = 2;
  localparam int SETTLE_CYC_DEF = 3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SETUP, ST_REQ, ST_WAIT, ST_SETTLE,
    ST_SAMPLE, ST_DECIDE, ST_WRITE, ST_DONE
  } state_e;
endpackage

// File: rtl/skew_sar.sv
// Successive-approximation register: trial code plus one-hot bit pointer.
// Ports: clk_i, arstn_i; load_i starts a search at MSB; decide_i resolves the
// current bit using maj_i (1 = clear the trial bit) and arms the next lower bit.
// code_o is the trial code, code_nxt_o the code after resolving the current
// bit (the final result when last_o=1), last_o flags bit 0 under trial.
module skew_sar #(
  parameter int DELAY_W = 10
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  input  logic               load_i,
  input  logic               decide_i,
  input  logic               maj_i,
  output logic [DELAY_W-1:0] code_o,
  output logic [DELAY_W-1:0] code_nxt_o,
  output logic               last_o
);
  localparam logic [DELAY_W-1:0] MSB = DELAY_W'(1) << (DELAY_W - 1);

  logic [DELAY_W-1:0] code_q, code_d, bit_q, bit_d, kept;

  always_comb begin
    kept   = maj_i ? (code_q & ~bit_q) : code_q;
    code_d = code_q;
    bit_d  = bit_q;
    if (load_i) begin
      code_d = MSB;
      bit_d  = MSB;
    end else if (decide_i) begin
      bit_d  = bit_q >> 1;
      code_d = kept | (bit_q >> 1);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      code_q <= '0;
      bit_q  <= '0;
    end else begin
      code_q <= code_d;
      bit_q  <= bit_d;
    end
  end

  assign code_o     = code_q;
  assign code_nxt_o = kept;
  assign last_o     = bit_q[0];
endmodule

// File: rtl/sync_ff.sv
// Two-stage synchroniser for one asynchronous level.
// Ports: clk_i, arstn_i (async active-low, resets to 0), d_i async in, q_o synced out.
module sync_ff (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) s_q <= '0;
    else          s_q <= {s_q[0], d_i};
  end

  assign q_o = s_q[1];
endmodule

// File: rtl/skew_mes_ctl_mc.sv
// Skew measurement controller: for each masked channel, binary-searches the
// strobe delay code at which the latched comparator flips, using a majority
// vote over 2^AVG_LOG2 strobes per bit.
// Ports: clk_i/arstn_i (async active-low), start_i + ch_mask_i run request,
// cmp_out_i async comparator levels, stb_req_o/stb_valid_i strobe handshake,
// delay_code_o/ch_sel_o trial setting, res_we_o/res_ch_o/res_code_o result
// write, busy_o/done_o/err_o status.
// Optional: define SKEW_MES_TIMEOUT_EN to time out a strobe wait after TMO_CYC
// cycles (sticky err_o, all-ones result for that channel).
module skew_mes_ctl_mc
  import skew_mes_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DELAY_W    = DELAY_W_DEF,
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int TMO_CYC    = 1024,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  input  logic               start_i,
  input  logic [N_CH-1:0]    ch_mask_i,
  input  logic [N_CH-1:0]    cmp_out_i,
  output logic               stb_req_o,
  input  logic               stb_valid_i,
  output logic [DELAY_W-1:0] delay_code_o,
  output logic [CH_W-1:0]    ch_sel_o,
  output logic               res_we_o,
  output logic [CH_W-1:0]    res_ch_o,
  output logic [DELAY_W-1:0] res_code_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);
  localparam int NS    = 1 << AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int STL_W = $clog2(SETTLE_CYC + 1) + 1;

  state_e             state_q, state_d;
  logic [N_CH-1:0]    pend_q, pend_d;
  logic [CH_W-1:0]    ch_q, ch_d, res_ch_q, res_ch_d, low_ch;
  logic [DELAY_W-1:0] res_code_q, res_code_d, code_nxt;
  logic [CNT_W-1:0]   smp_q, smp_d, ones_q, ones_d;
  logic [STL_W-1:0]   stl_q, stl_d;
  logic               stb_req_q, stb_req_d, busy_q, busy_d, done_q, done_d;
  logic               res_we_q, res_we_d, found, maj, sar_load, sar_decide, sar_last;
  logic [N_CH-1:0]    cmp_sync;
`ifdef SKEW_MES_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
`endif

  sync_ff u_sync [N_CH-1:0] (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .d_i    (cmp_out_i),
    .q_o    (cmp_sync)
  );

  // Tie resolves to 0: strictly more than half the strobes must see a 1.
  assign maj = ones_q > CNT_W'(NS / 2);

  skew_sar #(.DELAY_W(DELAY_W)) u_sar (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .load_i    (sar_load),
    .decide_i  (sar_decide),
    .maj_i     (maj),
    .code_o    (delay_code_o),
    .code_nxt_o(code_nxt),
    .last_o    (sar_last)
  );

  // Lowest pending channel.
  always_comb begin
    found  = 1'b0;
    low_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        found  = 1'b1;
        low_ch = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    ch_d       = ch_q;
    smp_d      = smp_q;
    ones_d     = ones_q;
    stl_d      = stl_q;
    stb_req_d  = stb_req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_we_d   = 1'b0;
    res_ch_d   = res_ch_q;
    res_code_d = res_code_q;
    sar_load   = 1'b0;
    sar_decide = 1'b0;
`ifdef SKEW_MES_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: if (start_i) begin
        pend_d  = ch_mask_i;
        busy_d  = 1'b1;
        state_d = ST_SETUP;
`ifdef SKEW_MES_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      ST_SETUP: begin
        if (found) begin
          ch_d           = low_ch;
          pend_d[low_ch] = 1'b0;
          sar_load       = 1'b1;
          smp_d          = '0;
          ones_d         = '0;
          stb_req_d      = 1'b1;
          state_d        = ST_REQ;
`ifdef SKEW_MES_TIMEOUT_EN
          tmo_d          = '0;
`endif
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      // REQ and WAIT both accept the strobe, so a strobe fired on the very
      // first request cycle is not lost.
      ST_REQ, ST_WAIT: begin
        if (stb_valid_i) begin
          stb_req_d = 1'b0;
          stl_d     = '0;
          state_d   = ST_SETTLE;
        end else begin
          state_d = ST_WAIT;
`ifdef SKEW_MES_TIMEOUT_EN
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
            err_d      = 1'b1;
            stb_req_d  = 1'b0;
            res_we_d   = 1'b1;
            res_ch_d   = ch_q;
            res_code_d = '1;
            state_d    = ST_WRITE;
          end
`endif
        end
      end
      ST_SETTLE: begin
        if (int'(stl_q) + 1 >= SETTLE_CYC) state_d = ST_SAMPLE;
        else                               stl_d   = stl_q + STL_W'(1);
      end
      ST_SAMPLE: begin
        ones_d = ones_q + CNT_W'(cmp_sync[ch_q]);
        smp_d  = smp_q + CNT_W'(1);
        if (smp_q == CNT_W'(NS - 1)) begin
          state_d = ST_DECIDE;
        end else begin
          stb_req_d = 1'b1;
          state_d   = ST_REQ;
`ifdef SKEW_MES_TIMEOUT_EN
          tmo_d     = '0;
`endif
        end
      end
      ST_DECIDE: begin
        sar_decide = 1'b1;
        if (sar_last) begin
          res_we_d   = 1'b1;
          res_ch_d   = ch_q;
          res_code_d = code_nxt;
          state_d    = ST_WRITE;
        end else begin
          smp_d     = '0;
          ones_d    = '0;
          stb_req_d = 1'b1;
          state_d   = ST_REQ;
`ifdef SKEW_MES_TIMEOUT_EN
          tmo_d     = '0;
`endif
        end
      end
      ST_WRITE: state_d = ST_SETUP;
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      ch_q       <= '0;
      smp_q      <= '0;
      ones_q     <= '0;
      stl_q      <= '0;
      stb_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_we_q   <= 1'b0;
      res_ch_q   <= '0;
      res_code_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ch_q       <= ch_d;
      smp_q      <= smp_d;
      ones_q     <= ones_d;
      stl_q      <= stl_d;
      stb_req_q  <= stb_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_we_q   <= res_we_d;
      res_ch_q   <= res_ch_d;
      res_code_q <= res_code_d;
    end
  end

`ifdef SKEW_MES_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign stb_req_o  = stb_req_q;
  assign ch_sel_o   = ch_q;
  assign res_we_o   = res_we_q;
  assign res_ch_o   = res_ch_q;
  assign res_code_o = res_code_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
endmodule
